// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a byte stream of the form
//   N[7:0], N[15:8], then N little-endian 32-bit words,
// and writes one word per WRITE cycle into the instruction memory.
// busy holds the core off while a session is in progress.
module imem_loader #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  // Widened so the oversize comparison is unsigned and width-matched.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [15:0]       len;          // word count N of the current session
  logic [15:0]       len_in;       // N as it will be once the high byte lands
  logic [1:0]        byte_cnt;     // byte lane within the word being assembled
  logic [23:0]       word_lo;      // lower three bytes of the word in flight
  logic [ADDR_W-1:0] addr_cnt;     // next write address
  logic              xfer;
  logic              start_ok;
  logic              last_word;

  assign len_in    = {byte_data, len[7:0]};
  assign xfer      = byte_valid && byte_ready;
  assign last_word = (words_loaded + 16'd1) == len;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and Moore/handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a
    // variable unassigned, which would infer a latch.
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    start_ok   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_in == 16'd0)                state_next = S_DONE;
          else if ({1'b0, len_in} > DEPTH_L)  state_next = S_ERROR;
          else                                state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid && byte_cnt == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        state_next = last_word ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          start_ok   = 1'b1;
          state_next = S_LEN_LO;
        end
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) begin
          start_ok   = 1'b1;
          state_next = S_LEN_LO;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, write-port registers, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      len          <= '0;
      byte_cnt     <= '0;
      word_lo      <= '0;
      addr_cnt     <= '0;
      words_loaded <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      if (start_ok) begin
        words_loaded <= '0;
        addr_cnt     <= '0;
        byte_cnt     <= '0;
      end

      if (xfer) begin
        unique case (state)
          S_LEN_LO: len[7:0]  <= byte_data;
          S_LEN_HI: len[15:8] <= byte_data;
          S_COLLECT: begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (byte_cnt)
              2'd0: word_lo[7:0]   <= byte_data;
              2'd1: word_lo[15:8]  <= byte_data;
              2'd2: word_lo[23:16] <= byte_data;
              2'd3: begin
                // Load the write port on the last byte so it is valid for
                // the whole WRITE cycle and holds afterwards.
                mem_wdata <= {byte_data, word_lo};
                mem_addr  <= addr_cnt;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end

      if (state == S_WRITE) begin
        addr_cnt     <= addr_cnt + ADDR_W'(1);
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random byte-stream loads scored against a
// word-level reference model; a monitor compares every memory write.
module tb_imem_loader;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int                checks = 0;
  int                errors = 0;
  wr_t               exp_q[$];
  logic [7:0]        stream[$];
  logic [31:0]       imem[DEPTH];
  int                n_writes = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  bit                exp_done;
  bit                exp_err;
  int                exp_wl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: derive the expected writes and final status from the
  // stream contents alone (count header, then little-endian words).
  task automatic model_load();
    int n;
    n        = {24'd0, stream[1], stream[0]};
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_wl   = 0;
    if (n == 0) exp_done = 1'b1;
    else if (n > DEPTH) exp_err = 1'b1;
    else begin
      for (int w = 0; w < n; w++) begin
        if (stream.size() >= 2 + 4 * (w + 1)) begin
          wr_t e;
          e.addr = ADDR_W'(w);
          e.data = {stream[2+4*w+3], stream[2+4*w+2], stream[2+4*w+1], stream[2+4*w]};
          exp_q.push_back(e);
          exp_wl++;
        end
      end
      exp_done = (exp_wl == n);
    end
  endtask

  task automatic set_len(input int n);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive the stream; a byte counts as sent only when valid meets ready.
  task automatic send_stream(input int gap_pct);
    int i = 0;
    int budget;
    budget = stream.size() * 20 + 50;
    while (i < stream.size() && budget > 0) begin
      @(negedge clk);
      budget--;
      byte_data  = stream[i];
      byte_valid = ($urandom_range(99) >= gap_pct);
      if (byte_valid && byte_ready) i++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (budget == 0) check("send_timeout", i, stream.size());
  endtask

  task automatic wait_end();
    int b = 200;
    while (!(done || error) && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("end_reached", 32'(done || error), 1);
  endtask

  task automatic check_final(input string tag);
    check({tag, "_words_loaded"}, words_loaded, exp_wl);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  // Monitor: every write is compared against the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        n_writes++;
        last_addr       = mem_addr;
        imem[mem_addr]  = mem_wdata;
        check("ready_low_in_write", byte_ready, 0);
        if (exp_q.size() == 0) check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e.addr);
          check("write_data", mem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Two-word load, valid held high.
    set_len(2);
    push_word(32'h00A00513);
    push_word(32'h00100593);
    model_load();
    n_writes = 0;
    do_start();
    check("busy_after_start", busy, 1);
    send_stream(0);
    wait_end();
    check_final("two_word");
    check("two_word_writes", n_writes, 2);
    check("readback0", imem[0], 32'h00A00513);
    check("readback1", imem[1], 32'h00100593);
    check("hold_addr", mem_addr, 1);
    check("hold_wdata", mem_wdata, 32'h00100593);

    // Zero-length session.
    set_len(0);
    model_load();
    n_writes = 0;
    do_start();
    send_stream(0);
    wait_end();
    check_final("zero");
    check("zero_writes", n_writes, 0);

    // Oversize count, then recovery via start.
    set_len(513);
    model_load();
    n_writes = 0;
    do_start();
    send_stream(0);
    wait_end();
    check_final("oversize");
    check("oversize_ready", byte_ready, 0);
    check("oversize_writes", n_writes, 0);
    set_len(1);
    push_word($urandom);
    model_load();
    do_start();
    send_stream(0);
    wait_end();
    check_final("recover");
    check("recover_writes", n_writes, 1);
    check("recover_addr", last_addr, 0);

    // Two-word load with random valid gaps.
    set_len(2);
    push_word(32'h00A00513);
    push_word(32'h00100593);
    model_load();
    n_writes = 0;
    do_start();
    send_stream(50);
    wait_end();
    check_final("gaps");
    check("gaps_writes", n_writes, 2);

    // Reset after two data bytes of the first word.
    set_len(2);
    push_word(32'h00A00513);
    void'(stream.pop_back());
    void'(stream.pop_back());
    model_load();
    n_writes = 0;
    do_start();
    send_stream(30);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset");
    repeat (3) @(negedge clk);
    check("mid_reset_writes", n_writes, 0);
    set_len(2);
    push_word($urandom);
    push_word($urandom);
    model_load();
    do_start();
    send_stream(0);
    wait_end();
    check_final("after_reset");
    check("after_reset_writes", n_writes, 2);

    // Full memory with a start pulse injected mid-load.
    set_len(DEPTH);
    for (int w = 0; w < DEPTH; w++) push_word($urandom);
    model_load();
    n_writes = 0;
    do_start();
    fork
      send_stream(10);
      begin
        repeat (1000) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_end();
    check_final("full");
    check("full_writes", n_writes, DEPTH);
    check("full_last_addr", last_addr, DEPTH - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
